// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multicycle ALU: single-cycle logic/arith, iterative one-bit-per-clock shifts
// Optional feature: define ALU_SRA_EN to enable arithmetic shift right on op code 1000.
module multicycle_alu #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [3:0]            ALU_Operation_i,
   input  logic [DATA_WIDTH-1:0] A_i,
   input  logic [DATA_WIDTH-1:0] B_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] ALU_Result_o,
   output logic                  Zero_o
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state_q, state_n;
   logic [DATA_WIDTH-1:0]  shreg_q, shreg_n;
   logic [SHAMT_WIDTH-1:0] cnt_q, cnt_n;
   logic                   left_q, left_n;
   logic                   fill_q, fill_n;
   logic [DATA_WIDTH-1:0]  result_q, result_n;
   logic                   zero_q, zero_n;

   logic [SHAMT_WIDTH-1:0] shamt;
   logic                   is_shift;
   logic                   is_arith;
   logic [DATA_WIDTH-1:0]  comb_res;
   logic [DATA_WIDTH-1:0]  step;

   assign shamt = B_i[SHAMT_WIDTH-1:0];

   always_comb begin
      is_shift = (ALU_Operation_i == 4'b0110) || (ALU_Operation_i == 4'b0111);
      is_arith = 1'b0;
`ifdef ALU_SRA_EN
      if (ALU_Operation_i == 4'b1000) begin
         is_shift = 1'b1;
         is_arith = 1'b1;
      end
`endif
   end

   // Shift ops only reach this path with shamt==0, so they pass A through.
   always_comb begin
      comb_res = '0;
      case (ALU_Operation_i)
         4'b0000: comb_res = A_i + B_i;
         4'b0001: comb_res = A_i - B_i;
         4'b0010: comb_res = A_i & B_i;
         4'b0011: comb_res = A_i | B_i;
         4'b0100: comb_res = A_i ^ B_i;
         4'b0101: comb_res = B_i;
         4'b0110: comb_res = A_i;
         4'b0111: comb_res = A_i;
`ifdef ALU_SRA_EN
         4'b1000: comb_res = A_i;
`endif
         default: comb_res = '0;
      endcase
   end

   // Right shifts fill with fill_q: zero for SRL, latched sign bit for SRA.
   assign step = left_q ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                        : {fill_q, shreg_q[DATA_WIDTH-1:1]};

   always_comb begin
      state_n  = state_q;
      shreg_n  = shreg_q;
      cnt_n    = cnt_q;
      left_n   = left_q;
      fill_n   = fill_q;
      result_n = result_q;
      zero_n   = zero_q;
      case (state_q)
         IDLE, DONE: begin
            state_n = IDLE;
            if (start_i) begin
               if (is_shift && (shamt != '0)) begin
                  state_n = SHIFT;
                  shreg_n = A_i;
                  cnt_n   = shamt;
                  left_n  = (ALU_Operation_i == 4'b0111);
                  fill_n  = is_arith & A_i[DATA_WIDTH-1];
               end else begin
                  state_n  = DONE;
                  result_n = comb_res;
                  zero_n   = (comb_res == '0);
               end
            end
         end
         SHIFT: begin
            shreg_n = step;
            cnt_n   = cnt_q - SHAMT_WIDTH'(1);
            if (cnt_q == SHAMT_WIDTH'(1)) begin
               state_n  = DONE;
               result_n = step;
               zero_n   = (step == '0);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         fill_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_n;
         shreg_q  <= shreg_n;
         cnt_q    <= cnt_n;
         left_q   <= left_n;
         fill_q   <= fill_n;
         result_q <= result_n;
         zero_q   <= zero_n;
      end
   end

   assign busy_o       = (state_q == SHIFT);
   assign done_o       = (state_q == DONE);
   assign ALU_Result_o = result_q;
   assign Zero_o       = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed self-checking bench for multicycle_alu
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;

   int vectors = 0;
   int miscompares = 0;

   multicycle_alu dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start),
      .ALU_Operation_i (op),
      .A_i             (a),
      .B_i             (b),
      .busy_o          (busy),
      .done_o          (done),
      .ALU_Result_o    (result),
      .Zero_o          (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one op (start high for the accepting edge), scrambles inputs after it,
   // then counts edges until done. Optionally pokes start during the first busy cycle.
   task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp, input int exp_lat,
                        input bit poke);
      int lat;
      int busy_cnt;
      bit stable;
      logic [31:0] prev;
      prev     = result;
      stable   = 1'b1;
      start    = 1'b1;
      op       = o;
      a        = av;
      b        = bv;
      @(posedge clk); #1;
      if (poke) begin
         op = 4'b0000; a = 32'h1; b = 32'h1;
      end else begin
         start = 1'b0; op = 4'hF; a = 32'hDEADBEEF; b = 32'h00000003;
      end
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         if (result !== prev) stable = 1'b0;
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
      end
      check({tag, " done"}, 32'(done), 32'h1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
      check({tag, " result"}, result, exp);
      check({tag, " zero"}, 32'(zero), 32'(exp == 32'h0));
      check({tag, " stable"}, 32'(stable), 32'h1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 4'h0; a = 32'h0; b = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'h0);
      check("reset done", 32'(done), 32'h0);
      check("reset result", result, 32'h0);
      check("reset zero", 32'(zero), 32'h1);
      reset = 1'b0;
      @(posedge clk); #1;

      do_op("add ovf", 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 1'b0);
      @(posedge clk); #1;
      check("done pulse width", 32'(done), 32'h0);
      do_op("sub eq", 4'b0001, 32'h5, 32'h5, 32'h0, 1, 1'b0);
      do_op("lui", 4'b0101, 32'hCAFEF00D, 32'h12345000, 32'h12345000, 1, 1'b0);
      do_op("and", 4'b0010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1, 1'b0);
      do_op("or", 4'b0011, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1, 1'b0);
      do_op("xor", 4'b0100, 32'h000000FF, 32'h0000000F, 32'h000000F0, 1, 1'b0);
      do_op("add wrap", 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1'b0);
      do_op("srl 31", 4'b0110, 32'h80000000, 32'd31, 32'h00000001, 32, 1'b0);
      do_op("sll 0", 4'b0111, 32'h000000A5, 32'h0, 32'h000000A5, 1, 1'b0);
      do_op("b2b add", 4'b0000, 32'h2, 32'h3, 32'h5, 1, 1'b0);
      do_op("bad op", 4'b1001, 32'h12, 32'h34, 32'h0, 1, 1'b0);
      do_op("sll shamt mask", 4'b0111, 32'h3, 32'h24, 32'h30, 5, 1'b0);
      do_op("srl poke", 4'b0110, 32'h000000F0, 32'h4, 32'h0000000F, 5, 1'b1);
`ifdef ALU_SRA_EN
      do_op("sra", 4'b1000, 32'h80000000, 32'h4, 32'hF8000000, 5, 1'b0);
`else
      do_op("op 1000 off", 4'b1000, 32'h80000000, 32'h4, 32'h0, 1, 1'b0);
`endif
      do_op("add nz", 4'b0000, 32'h10, 32'h1, 32'h11, 1, 1'b0);

      // Reset during the third shift cycle of SLL by 10 aborts without done.
      start = 1'b1; op = 4'b0111; a = 32'h1; b = 32'd10;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid shift busy", 32'(busy), 32'h1);
      check("mid shift result held", result, 32'h11);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort busy", 32'(busy), 32'h0);
      check("abort done", 32'(done), 32'h0);
      check("abort result", result, 32'h0);
      check("abort zero", 32'(zero), 32'h1);
      repeat (12) begin
         @(posedge clk); #1;
         check("no late done", 32'(done), 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
